// File: rtl/clock_time_keeper.sv
// Time-of-day register (mm:ss as 0..TIME_MAX seconds) with 1 s timebase,
// set-mode mirroring and alarm ringing control.
module clock_time_keeper #(
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned TIME_MAX      = 3599,
  parameter int unsigned RING_SEC      = 30
) (
  input  logic        CLOCK_1ms,
  input  logic        RESET,
  input  logic        SET_ACTIVE,
  input  logic [11:0] TIME_SET,
  input  logic        time_flows,
  input  logic [11:0] ALARM_TIME,
  input  logic        ALARM_EN,
  input  logic        ALARM_ACK,
  output logic [11:0] TIME_CURR,
  output logic        CLOCK_1s,
  output logic        TICK_1s,
  output logic        ALARM_RING
);

  localparam int unsigned MsW   = $clog2(TICKS_PER_SEC);
  localparam int unsigned RingW = $clog2(RING_SEC) + 1;

  localparam logic [MsW-1:0]   MsLast   = MsW'(TICKS_PER_SEC - 1);
  localparam logic [MsW-1:0]   MsHalf   = MsW'(TICKS_PER_SEC / 2);
  localparam logic [11:0]      TimeMax  = 12'(TIME_MAX);
  localparam logic [RingW-1:0] RingLast = RingW'(RING_SEC - 1);

  typedef enum logic [0:0] {StIdle, StRinging} state_e;

  logic [MsW-1:0]   r_ms_cnt, w_ms_cnt_d;
  logic [11:0]      r_time, w_time_d, w_time_inc;
  logic             r_clk_1s, r_tick, r_set_d, r_ack_d;
  state_e           r_state, w_state_d;
  logic [RingW-1:0] r_ring_cnt, w_ring_cnt_d;
  logic             w_tick, w_set_fall, w_ack_rise, w_inc, w_exit;

  assign w_tick     = (r_ms_cnt == MsLast);
  assign w_set_fall = r_set_d && !SET_ACTIVE;
  assign w_ack_rise = ALARM_ACK && !r_ack_d;
  assign w_inc      = !SET_ACTIVE && w_tick && time_flows;
  assign w_time_inc = (r_time == TimeMax) ? 12'd0 : r_time + 12'd1;
  assign w_exit     = w_ack_rise || !ALARM_EN || SET_ACTIVE || (w_tick && (r_ring_cnt == RingLast));

  // Leaving set mode restarts the second so the first run second is full length.
  assign w_ms_cnt_d = (w_set_fall || w_tick) ? '0 : r_ms_cnt + MsW'(1);

  // The first set-mode cycle is skipped: the setting block is still loading from TIME_CURR.
  always_comb begin
    w_time_d = r_time;
    if (SET_ACTIVE) begin
      if (r_set_d) begin
        w_time_d = (TIME_SET > TimeMax) ? 12'd0 : TIME_SET;
      end
    end else if (w_tick && time_flows) begin
      w_time_d = w_time_inc;
    end
  end

  // Only a run-mode increment can start ringing; exit conditions take priority.
  always_comb begin
    w_state_d    = r_state;
    w_ring_cnt_d = r_ring_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_inc && ALARM_EN && (w_time_inc == ALARM_TIME)) begin
          w_state_d    = StRinging;
          w_ring_cnt_d = '0;
        end
      end
      StRinging: begin
        if (w_exit) begin
          w_state_d = StIdle;
        end else if (w_tick) begin
          w_ring_cnt_d = r_ring_cnt + RingW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_1ms or posedge RESET) begin
    if (RESET) begin
      r_ms_cnt   <= '0;
      r_time     <= '0;
      r_clk_1s   <= 1'b0;
      r_tick     <= 1'b0;
      r_set_d    <= 1'b0;
      r_ack_d    <= 1'b0;
      r_state    <= StIdle;
      r_ring_cnt <= '0;
    end else begin
      r_ms_cnt   <= w_ms_cnt_d;
      r_time     <= w_time_d;
      r_clk_1s   <= (r_ms_cnt < MsHalf);
      r_tick     <= w_tick;
      r_set_d    <= SET_ACTIVE;
      r_ack_d    <= ALARM_ACK;
      r_state    <= w_state_d;
      r_ring_cnt <= w_ring_cnt_d;
    end
  end

  assign TIME_CURR  = r_time;
  assign CLOCK_1s   = r_clk_1s;
  assign TICK_1s    = r_tick;
  assign ALARM_RING = (r_state == StRinging);

endmodule

// File: tb/tb_clock_time_keeper.sv
// Bench for clock_time_keeper: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_clock_time_keeper;

  localparam int TPS      = 1000;
  localparam int TMAX     = 3599;
  localparam int RING_SEC = 30;

  logic        CLOCK_1ms, RESET, SET_ACTIVE, time_flows, ALARM_EN, ALARM_ACK;
  logic [11:0] TIME_SET, ALARM_TIME, TIME_CURR;
  logic        CLOCK_1s, TICK_1s, ALARM_RING;

  int total = 0;
  int bad   = 0;

  clock_time_keeper #(
    .TICKS_PER_SEC(TPS),
    .TIME_MAX     (TMAX),
    .RING_SEC     (RING_SEC)
  ) dut (
    .CLOCK_1ms (CLOCK_1ms),
    .RESET     (RESET),
    .SET_ACTIVE(SET_ACTIVE),
    .TIME_SET  (TIME_SET),
    .time_flows(time_flows),
    .ALARM_TIME(ALARM_TIME),
    .ALARM_EN  (ALARM_EN),
    .ALARM_ACK (ALARM_ACK),
    .TIME_CURR (TIME_CURR),
    .CLOCK_1s  (CLOCK_1s),
    .TICK_1s   (TICK_1s),
    .ALARM_RING(ALARM_RING)
  );

  initial begin
    CLOCK_1ms = 1'b0;
    forever #5 CLOCK_1ms = ~CLOCK_1ms;
  end

  // Behavioural model: phase within the second, seconds of day, seconds rung.
  int m_ms = 0, m_time = 0, m_rung = 0, t_next;
  bit m_ring = 0, m_set_d = 0, m_ack_d = 0, m_tick = 0, m_c1s = 0, t_tick, t_inc;

  always @(posedge CLOCK_1ms or posedge RESET) begin
    if (RESET) begin
      m_ms = 0; m_time = 0; m_rung = 0; m_ring = 0;
      m_set_d = 0; m_ack_d = 0; m_tick = 0; m_c1s = 0;
    end else begin
      t_tick = (m_ms == TPS - 1);
      t_inc  = 0;
      t_next = m_time;
      if (SET_ACTIVE) begin
        if (m_set_d) t_next = (int'(TIME_SET) > TMAX) ? 0 : int'(TIME_SET);
      end else if (t_tick && time_flows) begin
        t_next = (m_time + 1) % (TMAX + 1);
        t_inc  = 1;
      end
      if (m_ring) begin
        if (t_tick) m_rung++;
        if ((ALARM_ACK && !m_ack_d) || !ALARM_EN || SET_ACTIVE || m_rung == RING_SEC) m_ring = 0;
      end else if (t_inc && ALARM_EN && t_next == int'(ALARM_TIME)) begin
        m_ring = 1;
        m_rung = 0;
      end
      m_tick  = t_tick;
      m_c1s   = (m_ms < TPS / 2);
      m_ms    = (m_set_d && !SET_ACTIVE) ? 0 : (m_ms + 1) % TPS;
      m_time  = t_next;
      m_set_d = SET_ACTIVE;
      m_ack_d = ALARM_ACK;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLOCK_1ms);
      #2;
      check("model_time", 32'(TIME_CURR), 32'(m_time));
      check("model_clk1s", 32'(CLOCK_1s), 32'(m_c1s));
      check("model_tick", 32'(TICK_1s), 32'(m_tick));
      check("model_ring", 32'(ALARM_RING), 32'(m_ring));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_1ms);
  endtask

  // Enter set mode with a stale value first, then the edited value, hold, and leave.
  task automatic set_time(input int v, input int prev, input int hold);
    SET_ACTIVE = 1'b1;
    TIME_SET   = 12'd100;
    cyc(1);
    check("stale_not_mirrored", 32'(TIME_CURR), 32'(prev));
    TIME_SET = 12'(v);
    cyc(1);
    check("mirror", 32'(TIME_CURR), 32'(v));
    cyc(hold);
    SET_ACTIVE = 1'b0;
    cyc(1);
  endtask

  int n_tick, n_rise;
  logic prev_c1s;

  initial begin
    RESET = 1'b1; SET_ACTIVE = 1'b0; TIME_SET = '0; time_flows = 1'b0;
    ALARM_TIME = '0; ALARM_EN = 1'b0; ALARM_ACK = 1'b0;
    cyc(3);
    check("rst_time", 32'(TIME_CURR), 0);
    check("rst_clk1s", 32'(CLOCK_1s), 0);
    check("rst_tick", 32'(TICK_1s), 0);
    check("rst_ring", 32'(ALARM_RING), 0);

    // Free-running seconds.
    RESET = 1'b0; time_flows = 1'b1;
    cyc(500);  check("clk1s_hi_500", 32'(CLOCK_1s), 1);
    cyc(1);    check("clk1s_lo_501", 32'(CLOCK_1s), 0);
    cyc(498);  check("tick_999", 32'(TICK_1s), 0); check("time_999", 32'(TIME_CURR), 0);
    cyc(1);    check("tick_1000", 32'(TICK_1s), 1); check("time_1000", 32'(TIME_CURR), 1);
    cyc(2000); check("tick_3000", 32'(TICK_1s), 1); check("time_3000", 32'(TIME_CURR), 3);

    // Wrap from TIME_MAX.
    set_time(3599, 3, 0);
    cyc(999);  check("pre_wrap", 32'(TIME_CURR), 3599);
    cyc(1);    check("wrap", 32'(TIME_CURR), 0); check("wrap_tick", 32'(TICK_1s), 1);

    // Leave set mode mid-second: next increment a full second later.
    set_time(725, 0, 698);
    cyc(999);  check("full_sec_hold", 32'(TIME_CURR), 725);
    cyc(1);    check("full_sec_inc", 32'(TIME_CURR), 726);

    // Time frozen, timebase keeps running.
    time_flows = 1'b0; n_tick = 0; n_rise = 0; prev_c1s = CLOCK_1s;
    for (int i = 0; i < 5000; i++) begin
      cyc(1);
      if (TICK_1s) n_tick++;
      if (CLOCK_1s && !prev_c1s) n_rise++;
      prev_c1s = CLOCK_1s;
    end
    check("frozen_time", 32'(TIME_CURR), 726);
    check("frozen_ticks", 32'(n_tick), 5);
    check("frozen_clk1s_rises", 32'(n_rise), 5);
    time_flows = 1'b1;

    // Alarm acknowledged.
    ALARM_TIME = 12'd10; ALARM_EN = 1'b1;
    set_time(9, 726, 0);
    cyc(999);  check("pre_ring", 32'(ALARM_RING), 0);
    cyc(1);    check("ring_time", 32'(TIME_CURR), 10); check("ring_on", 32'(ALARM_RING), 1);
    cyc(2500); check("ring_held", 32'(ALARM_RING), 1); check("ring_held_time", 32'(TIME_CURR), 12);
    ALARM_ACK = 1'b1;
    cyc(1);    check("ack_stops", 32'(ALARM_RING), 0);
    ALARM_ACK = 1'b0;

    // Alarm times out after RING_SEC seconds.
    set_time(9, 12, 0);
    cyc(1000);  check("ring2_on", 32'(ALARM_RING), 1);
    cyc(29000); check("ring2_at39", 32'(ALARM_RING), 1); check("time39", 32'(TIME_CURR), 39);
    cyc(1000);  check("ring2_off", 32'(ALARM_RING), 0); check("time40", 32'(TIME_CURR), 40);

    // Loading the alarm time in set mode must not ring.
    set_time(10, 40, 0);
    check("set_no_ring", 32'(ALARM_RING), 0);
    cyc(1000);  check("set_no_ring_run", 32'(ALARM_RING), 0); check("time11", 32'(TIME_CURR), 11);

    // Asynchronous reset while ringing.
    set_time(9, 11, 0);
    cyc(1000);  check("ring3_on", 32'(ALARM_RING), 1);
    cyc(300);
    #2 RESET = 1'b1;
    #1;
    check("async_rst_ring", 32'(ALARM_RING), 0);
    check("async_rst_time", 32'(TIME_CURR), 0);
    cyc(2);
    RESET = 1'b0;

    // Randomized traffic against the model.
    ALARM_EN = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      cyc(1);
      TIME_SET = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(3600, 4095))
                                             : 12'($urandom_range(0, 3599));
      if (!SET_ACTIVE) begin
        if ($urandom_range(0, 1499) == 0) SET_ACTIVE = 1'b1;
      end else if ($urandom_range(0, 29) == 0) begin
        SET_ACTIVE = 1'b0;
        ALARM_TIME = 12'((m_time + int'($urandom_range(1, 4))) % (TMAX + 1));
      end
      if ($urandom_range(0, 3999) == 0) time_flows = !time_flows;
      if ($urandom_range(0, 5999) == 0) ALARM_EN = !ALARM_EN;
      if ($urandom_range(0, 1999) == 0) ALARM_ACK = !ALARM_ACK;
    end

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
